// File: rtl/lsu_mc.sv
// Multi-cycle LA32R load/store unit: request/acknowledge memory handshake with lane steering,
// load extension, and misalignment / bus-timeout error reporting.
module lsu_mc #(
  parameter int ADDR_W  = 16,
  parameter int MAX_LAT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  output logic [4:0]        rsp_rd,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on a clock edge where req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a single-cycle pulse with no back-pressure.
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic          r_unsigned;
  logic [1:0]    r_size;
  logic [1:0]    r_lane;
  logic [4:0]    r_rd;

  logic          w_misaligned;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ldata;

  assign req_ready = (r_state == S_IDLE);
  assign dbg_state = r_state;

  assign w_misaligned = (req_size == 2'd3) ||
                        (req_size == 2'd2 && req_addr[1:0] != 2'b00) ||
                        (req_size == 2'd1 && req_addr[0]);

  always_comb begin
    w_wdata = req_wdata;
    w_wstrb = 4'b1111;
    case (req_size)
      2'd0: begin
        w_wdata = {4{req_wdata[7:0]}};
        w_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'd1: begin
        w_wdata = {2{req_wdata[15:0]}};
        w_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load extraction uses the lane/size captured at accept, since req_* may change during WAIT.
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_lane)
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      2'd3:    w_byte = mem_rdata[31:24];
      default: ;
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_size)
      2'd0:    w_ldata = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      2'd1:    w_ldata = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_ldata = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= 2'd0;
      r_lane     <= 2'd0;
      r_rd       <= 5'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_wstrb  <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      rsp_valid  <= 1'b0;
      rsp_rd     <= 5'd0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_lane     <= req_addr[1:0];
            r_rd       <= req_rd;
            if (w_misaligned) begin
              r_state   <= S_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 2'b01;
              rsp_rdata <= 32'd0;
              rsp_rd    <= req_we ? 5'd0 : req_rd;
            end else begin
              r_state   <= S_WAIT;
              r_cnt     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_wstrb <= req_we ? w_wstrb : 4'b0000;
              mem_addr  <= req_addr[ADDR_W-1:2];
              mem_wdata <= req_we ? w_wdata : 32'd0;
            end
          end
        end
        S_WAIT: begin
          // An ack arriving on the final allowed cycle takes priority over the timeout.
          if (mem_ack) begin
            r_state   <= S_DONE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b00;
            rsp_rdata <= r_we ? 32'd0 : w_ldata;
            rsp_rd    <= r_we ? 5'd0 : r_rd;
          end else if (r_cnt == LAST_CNT) begin
            r_state   <= S_DONE;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 2'b10;
            rsp_rdata <= 32'd0;
            rsp_rd    <= r_we ? 5'd0 : r_rd;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          rsp_valid <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mc.sv
// Bench for lsu_mc: directed cases plus random accesses, checked by a scoreboard fed from
// a byte-level reference model of LA32R load/store semantics.
module tb_lsu_mc;
  localparam int AW = 16;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [4:0]    req_rd;
  logic          rsp_valid;
  logic [4:0]    rsp_rd;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_err;
  logic          mem_req, mem_we, mem_ack;
  logic [3:0]    mem_wstrb;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  logic [38:0] exp_q[$];
  logic [38:0] last_rsp;
  bit          have_last = 1'b0;

  always #5 clk = ~clk;

  lsu_mc #(.ADDR_W(AW), .MAX_LAT(ML)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accesses described as byte counts and offsets within the word.
  function automatic bit ref_mis(input logic [1:0] size, input logic [AW-1:0] addr);
    int n;
    if (size == 2'd3) return 1'b1;
    n = 1 << size;
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  function automatic logic [3:0] ref_strb(input bit we, input logic [1:0] size, input logic [AW-1:0] addr);
    logic [3:0] s;
    int n, off;
    s = 4'b0000;
    n = 1 << size;
    off = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) if (we && i >= off && i < off + n) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = 1 << size;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns,
                                           input logic [AW-1:0] addr, input logic [31:0] word);
    logic [31:0] v, mask;
    int n;
    n = 1 << size;
    v = word >> (8 * int'(addr[1:0]));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
  endtask

  // lat = WAIT cycle on which mem_ack is given (1..ML); 0 means never ack (timeout).
  task automatic access(input bit we, input logic [1:0] size, input bit uns, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int lat, input logic [31:0] word);
    int n;
    bit mis;
    logic [4:0] erd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_issue", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_rd = rd;
    mis = ref_mis(size, addr);
    erd = we ? 5'd0 : rd;
    if (mis) exp_q.push_back({erd, 32'd0, 2'b01});
    else if (lat == 0) exp_q.push_back({erd, 32'd0, 2'b10});
    else exp_q.push_back({erd, we ? 32'd0 : ref_load(size, uns, addr, word), 2'b00});
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = AW'($urandom); req_wdata = $urandom; req_rd = 5'($urandom);
    @(negedge clk);
    if (mis) begin
      chk("mis_no_mem_req", mem_req, 0);
      chk("mis_rsp_timing", rsp_valid, 1);
      return;
    end
    chk("mem_req_rise", mem_req, 1);
    chk("mem_addr", mem_addr, addr[AW-1:2]);
    chk("mem_we", mem_we, we);
    chk("mem_wstrb", mem_wstrb, ref_strb(we, size, addr));
    if (we) chk("mem_wdata", mem_wdata, ref_wdata(size, wd));
    for (int k = 1; k <= ML; k++) begin
      if (k > 1) begin
        @(negedge clk);
        chk("mem_req_held", mem_req, 1);
        chk("mem_wstrb_held", mem_wstrb, ref_strb(we, size, addr));
      end
      if (k == lat) begin
        mem_ack = 1'b1;
        mem_rdata = word;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        break;
      end
    end
    if (lat == 0) @(posedge clk);
    @(negedge clk);
    chk("rsp_timing", rsp_valid, 1);
    chk("mem_req_dropped", mem_req, 0);
  endtask

  // Monitor: pops an expectation for every response pulse; between pulses rsp_* must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_last = 1'b0;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=%h expected=none at %0t", {rsp_rd, rsp_rdata, rsp_err}, $time);
        end else begin
          chk("rsp_fields", {rsp_rd, rsp_rdata, rsp_err}, exp_q.pop_front());
        end
        last_rsp = {rsp_rd, rsp_rdata, rsp_err};
        have_last = 1'b1;
      end else if (have_last) begin
        chk("rsp_hold", {rsp_rd, rsp_rdata, rsp_err}, last_rsp);
      end
    end
  end

  initial begin
    int n;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = 32'd0; req_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    access(1'b1, 2'd2, 1'b0, 16'h0008, 32'hDEADBEEF, 5'd7, 2, 32'h0);
    access(1'b0, 2'd0, 1'b0, 16'h0003, 32'h0, 5'd5, 1, 32'h80123456);
    access(1'b0, 2'd0, 1'b1, 16'h0003, 32'h0, 5'd5, 3, 32'h80123456);
    access(1'b1, 2'd1, 1'b0, 16'h0006, 32'h0000ABCD, 5'd2, 1, 32'h0);
    access(1'b1, 2'd2, 1'b0, 16'h0002, 32'h11223344, 5'd1, 1, 32'h0);
    access(1'b0, 2'd1, 1'b0, 16'h0001, 32'h0, 5'd9, 1, 32'h0);
    access(1'b0, 2'd3, 1'b0, 16'h0004, 32'h0, 5'd10, 1, 32'h0);
    access(1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 5'd3, 0, 32'h0);
    access(1'b0, 2'd2, 1'b0, 16'h0014, 32'h0, 5'd4, ML, 32'h12345678);
    access(1'b0, 2'd1, 1'b0, 16'h0016, 32'h0, 5'd6, 2, 32'h9ABC0000);

    // Reset while a store is waiting on memory; a late ack must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 16'h0020; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("midwait_mem_req", mem_req, 1);
    rst_n = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 0);
      chk("post_rst_no_mem_req", mem_req, 0);
      chk("post_rst_ready", req_ready, 1);
    end

    for (int t = 0; t < 300; t++) begin
      access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), AW'($urandom), $urandom,
             5'($urandom), $urandom_range(0, ML), $urandom);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
